// File: rtl/mii_rx_nibble_aligner.sv
// rtl/mii_rx_nibble_aligner.sv - MII/RMII receive lane aligner with qualified one-hot lock
module mii_rx_nibble_aligner #(
  parameter  int DATA_W   = 4,
  parameter  int LOCK_CNT = 2,
  localparam int SHIFT_W  = $clog2(DATA_W)
) (
  input  logic               clk_25Mz,
  input  logic               rst,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               CRS,
  input  logic               RX_DV,
  input  logic               sync_en,
  output logic [DATA_W-1:0]  data_sinhr_out,
  output logic               data_valid,
  output logic [SHIFT_W-1:0] shift_out,
  output logic               locked,
  output logic               hunt_fail,
  output logic [7:0]         hunt_fail_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Run counter is 4 bits because LOCK_CNT never exceeds 15.
  localparam logic [3:0] LOCK_CNT_V = 4'(LOCK_CNT);

  state_t               state;
  logic [2*DATA_W-1:0]  hist;
  logic [3:0]           run_cnt;
  logic [SHIFT_W-1:0]   run_k;

  logic                 qual;
  logic                 one_hot;
  logic                 cand_valid;
  logic [SHIFT_W-1:0]   cand_k;
  logic [3:0]           run_cnt_nxt;
  logic                 lock_hit;

  // Hunt qualification: only train while the PHY reports carrier, valid data and the controller enables it.
  assign qual = CRS & RX_DV & sync_en;

  // A training word has exactly one bit set; zero and multi-bit words are ignored.
  assign one_hot = ($countones(data_in) == 1);

  // Repeating the previous word is not a fresh edge of the pattern, so it is not a candidate.
  assign cand_valid = qual && one_hot && (data_in != hist[DATA_W-1:0]);

  // Bit position of the set bit; only meaningful when one_hot is true.
  always_comb begin
    cand_k = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data_in[i]) begin
        cand_k = SHIFT_W'(i);
      end
    end
  end

  // A repeated position extends the run, a new position restarts it at one.
  assign run_cnt_nxt = (cand_k == run_k) ? (run_cnt + 4'd1) : 4'd1;
  assign lock_hit    = cand_valid && (run_cnt_nxt >= LOCK_CNT_V);

  // Lane FSM: owns state, run tracking, shift, lock status and the hunt-failure counter.
  always_ff @(posedge clk_25Mz or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      run_cnt       <= '0;
      run_k         <= '0;
      shift_out     <= '0;
      locked        <= 1'b0;
      hunt_fail     <= 1'b0;
      hunt_fail_cnt <= '0;
    end else begin
      hunt_fail <= 1'b0;
      case (state)
        ST_IDLE: begin
          run_cnt <= '0;
          run_k   <= '0;
          locked  <= 1'b0;
          if (qual) begin
            state <= ST_HUNT;
          end
        end
        ST_HUNT: begin
          if (!qual) begin
            // Losing qualification beats a lock that would land on the same edge.
            state     <= ST_IDLE;
            hunt_fail <= 1'b1;
            run_cnt   <= '0;
            run_k     <= '0;
            if (hunt_fail_cnt != 8'hFF) begin
              hunt_fail_cnt <= hunt_fail_cnt + 8'd1;
            end
          end else if (cand_valid) begin
            run_k   <= cand_k;
            run_cnt <= run_cnt_nxt;
            if (lock_hit) begin
              state     <= ST_LOCKED;
              locked    <= 1'b1;
              shift_out <= cand_k;
            end
          end
        end
        ST_LOCKED: begin
          // sync_en no longer matters; only the end of carrier or data valid ends the frame.
          if (!CRS || !RX_DV) begin
            state  <= ST_IDLE;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Data path: two-word history, shifted output window, and valid aligned with the output register.
  always_ff @(posedge clk_25Mz or posedge rst) begin
    if (rst) begin
      hist           <= '0;
      data_sinhr_out <= '0;
      data_valid     <= 1'b0;
    end else begin
      hist           <= {hist[DATA_W-1:0], data_in};
      data_sinhr_out <= hist[shift_out +: DATA_W];
      data_valid     <= locked;
    end
  end

endmodule

// File: doc/mii_rx_nibble_aligner.md
# mii_rx_nibble_aligner

Parametrised receive-lane aligner for the MII/RMII front end, sitting between the PHY receive pins and the frame parser. It keeps a two-word history of the receive bus and hunts for a one-hot training pattern during the preamble. Once the same bit position is seen LOCK_CNT times in a row, it locks the lane shift and outputs re-aligned words with a valid flag. Compared with the previous single-shot fixed-nibble version, it adds a qualified lock, lock/fail status and a failure counter.

## Interface
- DATA_W, 4, receive word width; power of two, ≥2
- LOCK_CNT, 2, consecutive identical candidates needed to lock; 1..15
- SHIFT_W (local), $clog2(DATA_W), width of shift value
- clk_25Mz  in  1  receive clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- data_in  in  DATA_W  raw receive word from PHY
- CRS  in  1  carrier sense
- RX_DV  in  1  receive data valid
- sync_en  in  1  hunt enable from the receive controller
- data_sinhr_out  out  DATA_W  aligned word
- data_valid  out  1  data_sinhr_out carries locked, aligned frame data
- shift_out  out  SHIFT_W  current lane shift
- locked  out  1  FSM in LOCKED
- hunt_fail  out  1  one-cycle pulse: hunt aborted without lock
- hunt_fail_cnt  out  8  saturating count of hunt_fail pulses

## Operation
- History: every cycle hist[DATA_W-1:0] <= data_in and hist[2*DATA_W-1:DATA_W] <= hist[DATA_W-1:0]. The history updates regardless of FSM state.
- Output: every cycle data_sinhr_out <= hist[shift+DATA_W-1 : shift], where shift = shift_out register. Bits above the shift come from the older word.
- qual = CRS & RX_DV & sync_en.
- Candidate: qual=1, data_in != hist[DATA_W-1:0], and data_in one-hot with bit k set gives candidate k. Non-one-hot words, including 0, give no candidate and do not change the run counter.
- Run counter run_cnt and run shift run_k:
  - Candidate k == run_k: run_cnt+1.
  - Otherwise: run_k <= k, run_cnt <= 1.
  - Both cleared to 0 in IDLE.
- FSM:
  - IDLE -> HUNT when qual=1.
  - HUNT -> LOCKED when a candidate makes run_cnt reach LOCK_CNT. In that cycle shift_out <= k. With LOCK_CNT=1 the first candidate locks.
  - HUNT -> IDLE when qual=0. This pulses hunt_fail and increments hunt_fail_cnt, which saturates at 255.
  - LOCKED -> IDLE when CRS=0 or RX_DV=0. sync_en is ignored in LOCKED.
- shift_out is frozen in LOCKED. It is retained through IDLE and HUNT until the next lock.
- In LOCKED, candidates are ignored; payload one-hot words never re-align.
- locked = (state==LOCKED). data_valid is locked delayed by 1 cycle, which matches the output register.

## Timing
- Reset: data_sinhr_out=0, data_valid=0, shift_out=0, locked=0, hunt_fail=0, hunt_fail_cnt=0, hist=0, state IDLE, run_cnt=0, run_k=0.
- Latency: data_in sampled at edge n appears in data_sinhr_out after edge n+1 for shift 0. For shift s>0, the output at n+1 combines word n (low bits) with word n-1 (high bits).
- Lock: the candidate edge sets locked and shift_out at the same edge. data_valid rises one edge later; the first valid word uses the new shift.
- Drop: RX_DV low at edge m clears locked at m and data_valid at m+1.
- Simultaneous events:
  - qual falls on the same edge a candidate would lock: the drop wins (IDLE, hunt_fail pulse, no lock).
  - hunt_fail_cnt at 255: hunt_fail still pulses; the count holds.
- Reset mid-frame: all outputs clear immediately (asynchronous). On release the FSM restarts in IDLE.

## Test plan
- Reset: assert rst mid-LOCKED with shift 3 -> all outputs 0 without waiting for a clock edge; after release, IDLE and shift_out=0.
- Lock at shift 2: DATA_W=4, LOCK_CNT=2, qual=1, data_in 0,4,0,4 -> locked=1 and shift_out=2 at the second 4. Then feed 0x9 then 0x6 -> data_sinhr_out=0x5 one edge after 0x6 is in hist[3:0], with data_valid=1.
- Candidate mismatch: data_in 0,1,0,8,0,8 -> run restarts at the first 8, lock with shift_out=3 at the second 8.
- Non-one-hot ignored: data_in 0,4,3,4 -> 0x3 gives no candidate, run_cnt is unchanged, lock at the second 4 with shift 2.
- Hunt abort: qual=1, data_in 0,2, then RX_DV=0 -> one hunt_fail pulse, hunt_fail_cnt=1, IDLE, locked stays 0. Repeat 256 times -> count holds at 255.
- Frame end: in LOCKED, drop CRS -> locked falls at that edge, data_valid one edge later, shift_out retained.
